seq_restoring_divider: RTL and testbench

- Multi-cycle restoring divider; the inverse companion to the team's ripple-carry adder and Wallace multiplier datapath.
- Computes quotient and remainder of an unsigned WIDTH-bit dividend by a WIDTH-bit divisor.
- Resolves one quotient bit per clock through a ripple-borrow subtractor.
- Sits beside the multiplier as the arithmetic unit's divide path.

---
 rtl/div_pkg.sv | 11 +
 rtl/seq_restoring_divider_if.sv | 8 +
 rtl/rbs_nbit.sv | 15 +
 rtl/seq_restoring_divider.sv | 80 ++++++++
 tb/tb_seq_restoring_divider.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// div_pkg: shared FSM state type, default width and counter sizing for the divider
package div_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  localparam int DIV_WIDTH_DEFAULT = 4;
  function automatic int cnt_w(input int w);
    int n;
    n = 0;
    for (int i = 0; i < 32; i++) if ((1 << i) < w + 1) n = i + 1;
    return n;
  endfunction
endpackage

// File: rtl/seq_restoring_divider_if.sv
// seq_restoring_divider_if: start/operand/result bundle for the divider
interface seq_restoring_divider_if #(parameter int WIDTH = div_pkg::DIV_WIDTH_DEFAULT);
  logic start;
  logic [WIDTH-1:0] dividend, divisor, quotient, remainder;
  logic busy, done, div_by_zero;
  modport master (output start, dividend, divisor, input busy, done, quotient, remainder, div_by_zero);
  modport slave (input start, dividend, divisor, output busy, done, quotient, remainder, div_by_zero);
endinterface

// File: rtl/rbs_nbit.sv
// rbs_nbit: ripple-borrow subtractor a-b built from full-adder cells (b inverted, carry-in 1)
module rbs_nbit #(parameter int WIDTH = 5) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);
  logic [WIDTH:0] c;
  assign c[0] = 1'b1;
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign diff[i] = a[i] ^ ~b[i] ^ c[i];
    assign c[i+1] = (a[i] & ~b[i]) | (c[i] & (a[i] ^ ~b[i]));
  end
  assign borrow = ~c[WIDTH];
endmodule

// File: rtl/seq_restoring_divider.sv
// seq_restoring_divider: one-quotient-bit-per-clock restoring divider; DIV_SIGNED_EN selects two's complement operands
module seq_restoring_divider import div_pkg::*; #(parameter int WIDTH = DIV_WIDTH_DEFAULT) (
  input logic clk,
  input logic rst,
  seq_restoring_divider_if.slave bus
);
  localparam int CW = cnt_w(WIDTH);
  state_t st;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] dvd, dvs, prem, prem_n, q_n, q_fin, r_fin, a_in, b_in;
  logic [WIDTH:0] shifted, diff;
  logic borrow, diff_top_unused;
  // dvd doubles as the quotient register: dividend bits leave at the top, quotient bits enter at the bottom
  assign shifted = {prem, dvd[WIDTH-1]};
  rbs_nbit #(.WIDTH(WIDTH + 1)) u_sub (.a(shifted), .b({1'b0, dvs}), .diff(diff), .borrow(borrow));
  assign diff_top_unused = diff[WIDTH];
  assign prem_n = borrow ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
  assign q_n = {dvd[WIDTH-2:0], ~borrow};
`ifdef DIV_SIGNED_EN
  logic sq, sr;
  assign a_in = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
  assign b_in = bus.divisor[WIDTH-1] ? -bus.divisor : bus.divisor;
  assign q_fin = sq ? -q_n : q_n;
  assign r_fin = sr ? -prem_n : prem_n;
`else
  assign a_in = bus.dividend;
  assign b_in = bus.divisor;
  assign q_fin = q_n;
  assign r_fin = prem_n;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= IDLE;
      cnt <= '0;
      dvd <= '0;
      dvs <= '0;
      prem <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.quotient <= '0;
      bus.remainder <= '0;
      bus.div_by_zero <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      if (st == RUN) begin
        prem <= prem_n;
        dvd <= q_n;
        cnt <= cnt - CW'(1);
        if (cnt == CW'(1)) begin
          st <= DONE;
          bus.busy <= 1'b0;
          bus.done <= 1'b1;
          bus.quotient <= q_fin;
          bus.remainder <= r_fin;
          bus.div_by_zero <= 1'b0;
        end
      end else begin
        st <= IDLE;
        if (bus.start && bus.divisor == '0) begin
          st <= DONE;
          bus.done <= 1'b1;
          bus.quotient <= '1;
          bus.remainder <= bus.dividend;
          bus.div_by_zero <= 1'b1;
        end else if (bus.start) begin
          st <= RUN;
          bus.busy <= 1'b1;
          dvd <= a_in;
          dvs <= b_in;
          prem <= '0;
          cnt <= CW'(WIDTH);
`ifdef DIV_SIGNED_EN
          sq <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
          sr <= bus.dividend[WIDTH-1];
`endif
        end
      end
    end
  end
endmodule

// File: tb/tb_seq_restoring_divider.sv
// tb_seq_restoring_divider: directed scenarios with hand-computed results for WIDTH=4
module tb_seq_restoring_divider;
  localparam int W = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errs = 0;
  int checks = 0;
  seq_restoring_divider_if #(.WIDTH(W)) bus ();
  seq_restoring_divider #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
    bus.dividend = a;
    bus.divisor = b;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask
  task automatic wait_done(output int n, output int nb);
    n = 0;
    nb = 0;
    while (!bus.done && n < 40) begin
      if (bus.busy) nb++;
      tick();
      n++;
    end
  endtask
  task automatic test_reset();
    int n;
    rst = 1'b1;
    bus.dividend = 4'd13;
    bus.divisor = 4'd3;
    bus.start = 1'b1;
    tick();
    tick();
    checks += 5;
    if (bus.busy !== 1'b0) begin errs++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    if (bus.done !== 1'b0) begin errs++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    if (bus.quotient !== 4'd0) begin errs++; $display("FAIL reset_q got=%0d exp=0", bus.quotient); end
    if (bus.remainder !== 4'd0) begin errs++; $display("FAIL reset_r got=%0d exp=0", bus.remainder); end
    if (bus.div_by_zero !== 1'b0) begin errs++; $display("FAIL reset_dbz got=%b exp=0", bus.div_by_zero); end
    bus.start = 1'b0;
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 3; i++) begin tick(); if (bus.busy || bus.done) n++; end
    checks++;
    if (n !== 0) begin errs++; $display("FAIL reset_idle_activity got=%0d exp=0", n); end
  endtask
  task automatic test_basic();
    int n, nb;
    launch(4'd13, 4'd3);
    wait_done(n, nb);
    checks += 6;
    if (n + 1 !== 5) begin errs++; $display("FAIL basic_latency got=%0d exp=5", n + 1); end
    if (nb !== 4) begin errs++; $display("FAIL basic_busy_cycles got=%0d exp=4", nb); end
    if (bus.quotient !== 4'b0100) begin errs++; $display("FAIL basic_q got=%b exp=0100", bus.quotient); end
    if (bus.remainder !== 4'b0001) begin errs++; $display("FAIL basic_r got=%b exp=0001", bus.remainder); end
    if (bus.div_by_zero !== 1'b0) begin errs++; $display("FAIL basic_dbz got=%b exp=0", bus.div_by_zero); end
    tick();
    if (bus.done !== 1'b0) begin errs++; $display("FAIL basic_done_width got=%b exp=0", bus.done); end
  endtask
  task automatic test_back_to_back();
    logic [W-1:0] a [3] = '{4'd15, 4'd5, 4'd0};
    logic [W-1:0] b [3] = '{4'd1, 4'd7, 4'd9};
    logic [W-1:0] eq [3] = '{4'd15, 4'd0, 4'd0};
    logic [W-1:0] er [3] = '{4'd0, 4'd5, 4'd0};
    int n, nb;
    for (int k = 0; k < 3; k++) begin
      launch(a[k], b[k]);
      wait_done(n, nb);
      checks += 3;
      if (n + 1 !== 5) begin errs++; $display("FAIL b2b%0d_latency got=%0d exp=5", k, n + 1); end
      if (bus.quotient !== eq[k]) begin errs++; $display("FAIL b2b%0d_q got=%0d exp=%0d", k, bus.quotient, eq[k]); end
      if (bus.remainder !== er[k]) begin errs++; $display("FAIL b2b%0d_r got=%0d exp=%0d", k, bus.remainder, er[k]); end
    end
    tick();
  endtask
  task automatic test_div_zero();
    int n, nb;
    launch(4'd9, 4'd0);
    wait_done(n, nb);
    checks += 7;
    if (n + 1 !== 1) begin errs++; $display("FAIL dz_latency got=%0d exp=1", n + 1); end
    if (bus.quotient !== 4'b1111) begin errs++; $display("FAIL dz_q got=%b exp=1111", bus.quotient); end
    if (bus.remainder !== 4'b1001) begin errs++; $display("FAIL dz_r got=%b exp=1001", bus.remainder); end
    if (bus.div_by_zero !== 1'b1) begin errs++; $display("FAIL dz_flag got=%b exp=1", bus.div_by_zero); end
    tick();
    if (bus.div_by_zero !== 1'b1) begin errs++; $display("FAIL dz_flag_hold got=%b exp=1", bus.div_by_zero); end
    launch(4'd6, 4'd2);
    wait_done(n, nb);
    if (bus.div_by_zero !== 1'b0) begin errs++; $display("FAIL dz_clear got=%b exp=0", bus.div_by_zero); end
    if (bus.quotient !== 4'd3) begin errs++; $display("FAIL dz_next_q got=%0d exp=3", bus.quotient); end
    tick();
  endtask
  task automatic test_ignore_start();
    int n, nb, dones;
    launch(4'd13, 4'd3);
    tick();
    bus.dividend = 4'd2;
    bus.divisor = 4'd1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_done(n, nb);
    checks += 5;
    if (n + 3 !== 5) begin errs++; $display("FAIL ign_latency got=%0d exp=5", n + 3); end
    if (bus.quotient !== 4'd4) begin errs++; $display("FAIL ign_q got=%0d exp=4", bus.quotient); end
    if (bus.remainder !== 4'd1) begin errs++; $display("FAIL ign_r got=%0d exp=1", bus.remainder); end
    dones = bus.done ? 1 : 0;
    for (int i = 0; i < 6; i++) begin tick(); if (bus.done) dones++; end
    if (dones !== 1) begin errs++; $display("FAIL ign_done_count got=%0d exp=1", dones); end
    if (bus.busy !== 1'b0) begin errs++; $display("FAIL ign_busy_after got=%b exp=0", bus.busy); end
  endtask
  task automatic test_reset_abort();
    int n, nb, dones;
    launch(4'd14, 4'd3);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks += 8;
    if (bus.busy !== 1'b0) begin errs++; $display("FAIL abort_busy got=%b exp=0", bus.busy); end
    if (bus.done !== 1'b0) begin errs++; $display("FAIL abort_done got=%b exp=0", bus.done); end
    if (bus.quotient !== 4'd0) begin errs++; $display("FAIL abort_q got=%0d exp=0", bus.quotient); end
    if (bus.remainder !== 4'd0) begin errs++; $display("FAIL abort_r got=%0d exp=0", bus.remainder); end
    dones = 0;
    for (int i = 0; i < 8; i++) begin tick(); if (bus.done || bus.busy) dones++; end
    if (dones !== 0) begin errs++; $display("FAIL abort_activity got=%0d exp=0", dones); end
    launch(4'd14, 4'd3);
    wait_done(n, nb);
    if (n + 1 !== 5) begin errs++; $display("FAIL abort_retry_latency got=%0d exp=5", n + 1); end
    if (bus.quotient !== 4'd4) begin errs++; $display("FAIL abort_retry_q got=%0d exp=4", bus.quotient); end
    if (bus.remainder !== 4'd2) begin errs++; $display("FAIL abort_retry_r got=%0d exp=2", bus.remainder); end
    tick();
  endtask
`ifdef DIV_SIGNED_EN
  task automatic test_signed();
    int n, nb;
    launch(4'b1001, 4'd2);
    wait_done(n, nb);
    checks += 5;
    if (n + 1 !== 5) begin errs++; $display("FAIL sgn_latency got=%0d exp=5", n + 1); end
    if (bus.quotient !== 4'b1101) begin errs++; $display("FAIL sgn_q got=%b exp=1101", bus.quotient); end
    if (bus.remainder !== 4'b1111) begin errs++; $display("FAIL sgn_r got=%b exp=1111", bus.remainder); end
    launch(4'b1000, 4'b1111);
    wait_done(n, nb);
    if (bus.quotient !== 4'b1000) begin errs++; $display("FAIL sgn_ovf_q got=%b exp=1000", bus.quotient); end
    if (bus.remainder !== 4'b0000) begin errs++; $display("FAIL sgn_ovf_r got=%b exp=0000", bus.remainder); end
    tick();
  endtask
`endif
  initial begin
    bus.start = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;
    test_reset();
`ifdef DIV_SIGNED_EN
    test_signed();
`else
    test_basic();
    test_back_to_back();
    test_ignore_start();
`endif
    test_div_zero();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
